// File: rtl/exwb_sched_pipe.sv
// Decode/execute/writeback core: register file, scoreboarded issue of ADD/ADDI/MUL into
// two fixed-latency pipes that share one writeback port.
module exwb_sched_pipe #(
    parameter int WIDTH   = 32,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 3,
    parameter int NREG    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic [11:0]      imm,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             busy,
    output logic             err,
    input  logic [4:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_MUL  = 3'b010,
        OP_ADDI = 3'b011
    } opcode_e;

    // A MUL in this stage retires in the same cycle a newly issued ADD would.
    localparam int SLOT = MUL_LAT - ADD_LAT;

    logic [WIDTH-1:0] rf_q [NREG];
    logic [31:0]      pending_q, pending_d;
    logic             err_q, err_d;

    logic [ADD_LAT-1:0] addValid_q;
    logic [4:0]         addRd_q  [ADD_LAT];
    logic [WIDTH-1:0]   addRes_q [ADD_LAT];
    logic [MUL_LAT-1:0] mulValid_q;
    logic [4:0]         mulRd_q  [MUL_LAT];
    logic [WIDTH-1:0]   mulRes_q [MUL_LAT];

    logic             isAdd, isAddi, isMul, isPipeOp, isIllegal;
    logic             srcHazard, slotHazard, issue;
    logic [WIDTH-1:0] opA, opB, immExt, addResult, mulResult;

    function automatic logic [WIDTH-1:0] rfRead(input logic [4:0] addr);
        if (addr == 5'd0 || int'(addr) >= NREG) begin
            return '0;
        end
        return rf_q[addr];
    endfunction

    always_comb begin
        isAdd     = (opcode == OP_ADD);
        isAddi    = (opcode == OP_ADDI);
        isMul     = (opcode == OP_MUL);
        isPipeOp  = isAdd | isAddi | isMul;
        isIllegal = ~isPipeOp & (opcode != OP_NOP);
    end

    // ADDI has no second source, so rs2 must not stall it.
    always_comb begin
        srcHazard  = pending_q[rs1] | pending_q[rd] | (~isAddi & pending_q[rs2]);
        slotHazard = (isAdd | isAddi) & mulValid_q[SLOT-1];
        in_ready   = ~isPipeOp | ~(srcHazard | slotHazard);
        issue      = in_valid & in_ready;
    end

    always_comb begin
        opA       = rfRead(rs1);
        opB       = rfRead(rs2);
        immExt    = {{(WIDTH-12){imm[11]}}, imm};
        addResult = opA + (isAddi ? immExt : opB);
        mulResult = opA * opB;
    end

    // Issue rules guarantee at most one final stage is occupied per cycle.
    always_comb begin
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        if (mulValid_q[MUL_LAT-1]) begin
            wb_valid = 1'b1;
            wb_rd    = mulRd_q[MUL_LAT-1];
            wb_data  = mulRes_q[MUL_LAT-1];
        end else if (addValid_q[ADD_LAT-1]) begin
            wb_valid = 1'b1;
            wb_rd    = addRd_q[ADD_LAT-1];
            wb_data  = addRes_q[ADD_LAT-1];
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (wb_valid) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (issue && isPipeOp) begin
            pending_d[rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
        err_d = err_q | (issue & isIllegal);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addValid_q <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                addRd_q[i]  <= '0;
                addRes_q[i] <= '0;
            end
        end else begin
            for (int i = ADD_LAT-1; i > 0; i--) begin
                addValid_q[i] <= addValid_q[i-1];
                addRd_q[i]    <= addRd_q[i-1];
                addRes_q[i]   <= addRes_q[i-1];
            end
            addValid_q[0] <= issue & (isAdd | isAddi);
            addRd_q[0]    <= rd;
            addRes_q[0]   <= addResult;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mulValid_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                mulRd_q[i]  <= '0;
                mulRes_q[i] <= '0;
            end
        end else begin
            for (int i = MUL_LAT-1; i > 0; i--) begin
                mulValid_q[i] <= mulValid_q[i-1];
                mulRd_q[i]    <= mulRd_q[i-1];
                mulRes_q[i]   <= mulRes_q[i-1];
            end
            mulValid_q[0] <= issue & isMul;
            mulRd_q[0]    <= rd;
            mulRes_q[0]   <= mulResult;
        end
    end

    // Register 0 is never written; reads of it are forced to zero in rfRead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_valid && wb_rd != 5'd0 && int'(wb_rd) < NREG) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        busy     = (|addValid_q) | (|mulValid_q);
        err      = err_q;
        dbg_data = rfRead(dbg_addr);
    end

endmodule

// File: tb/tb_exwb_sched_pipe.sv
// Self-checking bench for exwb_sched_pipe: directed table, multi-cycle corner sequences and
// randomized traffic against an in-flight-list reference model.
module tb_exwb_sched_pipe;

    localparam int WIDTH   = 32;
    localparam int ADD_LAT = 1;
    localparam int MUL_LAT = 3;
    localparam int NREG    = 32;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] MUL  = 3'b010;
    localparam logic [2:0] ADDI = 3'b011;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       opcode = NOP;
    logic [4:0]       rs1 = '0, rs2 = '0, rd = '0;
    logic [11:0]      imm = '0;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             busy, err;
    logic [4:0]       dbg_addr = '0;
    logic [WIDTH-1:0] dbg_data;

    always #5 clk = ~clk;

    exwb_sched_pipe #(.WIDTH(WIDTH), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .busy(busy), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference model: architectural registers plus a list of results still in flight,
    // each tagged with the clock edge at which it becomes architecturally visible.
    typedef struct {
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
        int               retireEdge;
        bit               isMul;
    } flight_t;

    flight_t          infl[$];
    logic [WIDTH-1:0] mrf [NREG];
    bit               mErr;
    int               edgeCnt;
    bit               lastReady;
    int               vectors = 0;
    int               miscompares = 0;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [11:0] imm;
        logic [4:0]  chkReg;
        logic [31:0] expVal;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mrfRead(input logic [4:0] r);
        return (r == 5'd0) ? '0 : mrf[r];
    endfunction

    function automatic bit isPending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (infl[i]) if (infl[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit isPipeOp(input logic [2:0] op);
        return (op == ADD) || (op == ADDI) || (op == MUL);
    endfunction

    // A new ADD/ADDI would retire ADD_LAT edges after the coming one; no MUL may retire then.
    function automatic bit modelReady(input logic [2:0] op, input logic [4:0] a, b, d);
        if (!isPipeOp(op)) return 1'b1;
        if (isPending(a) || isPending(d)) return 1'b0;
        if (op != ADDI && isPending(b)) return 1'b0;
        if (op != MUL) begin
            foreach (infl[i])
                if (infl[i].isMul && infl[i].retireEdge == edgeCnt + 1 + ADD_LAT) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] modelCompute(input logic [2:0] op,
                                                      input logic [WIDTH-1:0] a, b,
                                                      input logic [11:0] im);
        logic signed [WIDTH-1:0] sImm;
        logic [2*WIDTH-1:0]      prod;
        sImm = WIDTH'($signed(im));
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (op)
            ADD:     return a + b;
            ADDI:    return a + sImm;
            MUL:     return prod[WIDTH-1:0];
            default: return '0;
        endcase
    endfunction

    task automatic modelReset();
        infl.delete();
        for (int i = 0; i < NREG; i++) mrf[i] = '0;
        mErr    = 1'b0;
        edgeCnt = 0;
    endtask

    task automatic checkOutput();
        int idx;
        idx = -1;
        foreach (infl[i]) if (infl[i].retireEdge == edgeCnt + 1) idx = i;
        lastReady = modelReady(opcode, rs1, rs2, rd);
        check("in_ready", 64'(in_ready), 64'(lastReady));
        check("wb_valid", 64'(wb_valid), 64'(idx >= 0));
        if (idx >= 0) begin
            check("wb_rd", 64'(wb_rd), 64'(infl[idx].rd));
            check("wb_data", 64'(wb_data), 64'(infl[idx].data));
        end
        check("busy", 64'(busy), 64'(infl.size() != 0));
        check("err", 64'(err), 64'(mErr));
        check("dbg_data", 64'(dbg_data), 64'(mrfRead(dbg_addr)));
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [4:0] a, b, d,
                                 input logic [11:0] im, output bit issued);
        logic [WIDTH-1:0] res;
        int               thisEdge;
        @(negedge clk);
        in_valid = v;
        opcode   = op;
        rs1      = a;
        rs2      = b;
        rd       = d;
        imm      = im;
        dbg_addr = 5'($urandom_range(0, NREG-1));
        #1;
        checkOutput();
        issued = v && lastReady;
        res    = modelCompute(op, mrfRead(a), mrfRead(b), im);
        @(posedge clk);
        thisEdge = edgeCnt + 1;
        for (int i = infl.size() - 1; i >= 0; i--) begin
            if (infl[i].retireEdge == thisEdge) begin
                if (infl[i].rd != 5'd0) mrf[infl[i].rd] = infl[i].data;
                infl.delete(i);
            end
        end
        if (issued) begin
            if (isPipeOp(op))
                infl.push_back('{rd: d, data: res, isMul: (op == MUL),
                                 retireEdge: thisEdge + ((op == MUL) ? MUL_LAT : ADD_LAT)});
            else if (op != NOP)
                mErr = 1'b1;
        end
        edgeCnt = thisEdge;
    endtask

    task automatic issueOp(input logic [2:0] op, input logic [4:0] a, b, d,
                           input logic [11:0] im, output int stalls);
        bit ok;
        ok     = 1'b0;
        stalls = 0;
        for (int t = 0; t < 30 && !ok; t++) begin
            applyStimulus(1'b1, op, a, b, d, im, ok);
            if (!ok) stalls++;
        end
        if (!ok) check("issue_timeout", 64'(ok), 64'(1));
    endtask

    task automatic idle(input int n);
        bit ok;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, NOP, '0, '0, '0, '0, ok);
    endtask

    task automatic peek(input string name, input logic [4:0] r, input logic [WIDTH-1:0] exp);
        @(negedge clk);
        dbg_addr = r;
        #1;
        check(name, 64'(dbg_data), 64'(exp));
    endtask

    task automatic doReset(input bit fullCheck);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        opcode   = ADD;
        rs1      = 5'd1;
        rs2      = 5'd2;
        rd       = 5'd3;
        modelReset();
        #1;
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        check("rst_wb_rd", 64'(wb_rd), 64'(0));
        check("rst_wb_data", 64'(wb_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        if (fullCheck) begin
            for (int r = 0; r < NREG; r++) begin
                @(negedge clk);
                dbg_addr = 5'(r);
                #1;
                check("rst_dbg", 64'(dbg_data), 64'(0));
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  stalls;
        bit  ok;
        int  sel;
        logic [2:0] op;

        tbl[0]  = '{ADDI, 5'd0,  5'd0,  5'd1,  12'hFFB, 5'd1,  32'hFFFF_FFFB};
        tbl[1]  = '{ADDI, 5'd0,  5'd0,  5'd2,  12'h007, 5'd2,  32'd7};
        tbl[2]  = '{ADDI, 5'd0,  5'd0,  5'd3,  12'h006, 5'd3,  32'd6};
        tbl[3]  = '{MUL,  5'd2,  5'd3,  5'd4,  12'h000, 5'd4,  32'd42};
        tbl[4]  = '{ADD,  5'd4,  5'd2,  5'd5,  12'h000, 5'd5,  32'd49};
        tbl[5]  = '{ADDI, 5'd1,  5'd0,  5'd6,  12'h005, 5'd6,  32'd0};
        tbl[6]  = '{ADDI, 5'd0,  5'd0,  5'd7,  12'hFFF, 5'd7,  32'hFFFF_FFFF};
        tbl[7]  = '{ADD,  5'd7,  5'd7,  5'd8,  12'h000, 5'd8,  32'hFFFF_FFFE};
        tbl[8]  = '{MUL,  5'd7,  5'd7,  5'd9,  12'h000, 5'd9,  32'd1};
        tbl[9]  = '{ADDI, 5'd0,  5'd0,  5'd10, 12'h7FF, 5'd10, 32'h0000_07FF};
        tbl[10] = '{ADDI, 5'd0,  5'd0,  5'd11, 12'h800, 5'd11, 32'hFFFF_F800};
        tbl[11] = '{ADD,  5'd2,  5'd3,  5'd0,  12'h000, 5'd0,  32'd0};
        tbl[12] = '{MUL,  5'd10, 5'd10, 5'd12, 12'h000, 5'd12, 32'h003F_F001};

        modelReset();
        doReset(1'b1);

        foreach (tbl[i]) issueOp(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm, stalls);
        idle(MUL_LAT + 1);
        foreach (tbl[i]) peek("table_reg", tbl[i].chkReg, tbl[i].expVal);

        doReset(1'b0);

        // ADDI result appears on the writeback port one cycle after issue.
        issueOp(ADDI, 5'd0, 5'd0, 5'd1, 12'hFFB, stalls);
        #2;
        check("t2_wb_valid", 64'(wb_valid), 64'(1));
        check("t2_wb_rd", 64'(wb_rd), 64'(1));
        check("t2_wb_data", 64'(wb_data), 64'(32'hFFFF_FFFB));
        idle(1);
        #2;
        dbg_addr = 5'd1;
        #1;
        check("t2_dbg_r1", 64'(dbg_data), 64'(32'hFFFF_FFFB));

        // RAW on a MUL result: the dependent ADD waits until r4 retires.
        issueOp(ADDI, 5'd0, 5'd0, 5'd2, 12'h007, stalls);
        issueOp(ADDI, 5'd0, 5'd0, 5'd3, 12'h006, stalls);
        issueOp(MUL, 5'd2, 5'd3, 5'd4, 12'h000, stalls);
        issueOp(ADD, 5'd4, 5'd2, 5'd5, 12'h000, stalls);
        check("t3_raw_stalls", 64'(stalls), 64'(MUL_LAT));
        idle(MUL_LAT + 1);
        peek("t3_r4", 5'd4, 32'd42);
        peek("t3_r5", 5'd5, 32'd49);

        // Writeback slot collision: ADDI two cycles behind a MUL is held one cycle.
        issueOp(MUL, 5'd2, 5'd3, 5'd13, 12'h000, stalls);
        applyStimulus(1'b0, NOP, '0, '0, '0, '0, ok);
        applyStimulus(1'b1, ADDI, 5'd0, 5'd0, 5'd14, 12'h001, ok);
        check("t4_slot_blocked", 64'(ok), 64'(0));
        applyStimulus(1'b1, ADDI, 5'd0, 5'd0, 5'd14, 12'h001, ok);
        check("t4_slot_issued", 64'(ok), 64'(1));
        idle(MUL_LAT + 1);
        peek("t4_r13", 5'd13, 32'd42);
        peek("t4_r14", 5'd14, 32'd1);

        // Wraparound arithmetic, then an illegal opcode.
        issueOp(ADDI, 5'd0, 5'd0, 5'd1, 12'hFFF, stalls);
        issueOp(ADD, 5'd1, 5'd1, 5'd2, 12'h000, stalls);
        issueOp(MUL, 5'd1, 5'd1, 5'd3, 12'h000, stalls);
        idle(MUL_LAT + 1);
        peek("t5_add_wrap", 5'd2, 32'hFFFF_FFFE);
        peek("t5_mul_wrap", 5'd3, 32'h0000_0001);
        issueOp(3'b111, 5'd1, 5'd1, 5'd5, 12'h000, stalls);
        #2;
        check("t5_err_set", 64'(err), 64'(1));
        idle(3);
        #2;
        check("t5_err_held", 64'(err), 64'(1));
        peek("t5_rf_unchanged", 5'd5, 32'd49);

        // Reset while a MUL is in flight: it must never retire.
        issueOp(MUL, 5'd2, 5'd3, 5'd8, 12'h000, stalls);
        idle(1);
        @(negedge clk);
        in_valid = 1'b0;
        opcode   = ADD;
        rs1      = 5'd8;
        rs2      = 5'd0;
        rd       = 5'd8;
        dbg_addr = 5'd8;
        rst      = 1'b1;
        modelReset();
        #1;
        check("t6_wb_valid", 64'(wb_valid), 64'(0));
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_pending_clear", 64'(in_ready), 64'(1));
        check("t6_err_clear", 64'(err), 64'(0));
        check("t6_r8", 64'(dbg_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        idle(MUL_LAT + 1);
        peek("t6_r8_after", 5'd8, 32'd0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      op = NOP;
            else if (sel <= 3) op = ADD;
            else if (sel <= 6) op = ADDI;
            else if (sel <= 8) op = MUL;
            else               op = 3'($urandom_range(4, 7));
            applyStimulus(($urandom_range(0, 3) != 0), op,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 12'($urandom), ok);
        end
        idle(MUL_LAT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
